// File: rtl/mc_controller_v2_if.sv
// Memory request/ready handshake between the multi-cycle controller and the unified memory.
// The controller drives the request side (master); memory answers with MemReady (slave).
interface mc_controller_v2_if;
  logic MemReq;
  logic MemWrite;
  logic AdrSrc;
  logic MemReady;

  modport master (output MemReq, output MemWrite, output AdrSrc, input MemReady);
  modport slave  (input MemReq, input MemWrite, input AdrSrc, output MemReady);
endinterface

// File: rtl/mc_controller_v2.sv
// Multi-cycle RV32I control unit with memory wait states, bus timeout and sticky halt.
// Define MC_PERF_CNT_EN to add the CycleCnt/InstretCnt performance counters.
module mc_controller_v2 #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  mc_controller_v2_if.master      mem,
  input  logic [6:0]              op,
  input  logic [2:0]              func3,
  input  logic [6:0]              func7,
  input  logic                    Zero,
  input  logic                    sign,
  input  logic                    Ltu,
  output logic                    IrWrite,
  output logic                    PcWrite,
  output logic                    RegWrite,
  output logic [1:0]              ALUSrcA,
  output logic [1:0]              ALUSrcB,
  output logic [1:0]              ResultSrc,
  output logic [3:0]              ALUControl,
  output logic [2:0]              ImmSrc,
  output logic                    Halted,
  output logic [1:0]              Cause
`ifdef MC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]        CycleCnt,
  output logic [CNT_W-1:0]        InstretCnt
`endif
);

  localparam logic [4:0] S_FETCH  = 5'd0,  S_DECODE = 5'd1,  S_BRANCH = 5'd2,  S_LUI    = 5'd3;
  localparam logic [4:0] S_AUIPC  = 5'd4,  S_MEMADR = 5'd5,  S_MEMWR  = 5'd6,  S_MEMRD  = 5'd7;
  localparam logic [4:0] S_MEMWB  = 5'd8,  S_EXEC_R = 5'd9,  S_EXEC_I = 5'd10, S_ALUWB  = 5'd11;
  localparam logic [4:0] S_JAL    = 5'd12, S_JALR   = 5'd13, S_JUMP   = 5'd14, S_JUMPWB = 5'd15;
  localparam logic [4:0] S_HALT   = 5'd16;

  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010, ALU_OR = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0100, ALU_XOR = 4'b0101, ALU_SLTU = 4'b0110;

  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

  if (MEM_TIMEOUT < 0) begin : g_bad_timeout
    $error("MEM_TIMEOUT must be non-negative");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be positive");
  end

  logic [4:0]        state_reg, state_next;
  logic [1:0]        cause_reg, cause_next;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic              timeout_hit;
  logic              in_req_state;

  // Counter sitting at the limit means the allowed wait cycles are spent; MemReady still wins.
  assign timeout_hit  = (MEM_TIMEOUT != 0) && (wait_cnt_reg == WAIT_LIMIT);
  assign in_req_state = (state_reg == S_FETCH) || (state_reg == S_MEMRD) || (state_reg == S_MEMWR);

  always_comb begin
    state_next   = state_reg;
    cause_next   = cause_reg;
    mem.MemReq   = 1'b0;
    mem.MemWrite = 1'b0;
    mem.AdrSrc   = 1'b0;
    IrWrite      = 1'b0;
    PcWrite      = 1'b0;
    RegWrite     = 1'b0;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    ResultSrc    = 2'b00;
    ALUControl   = ALU_ADD;
    ImmSrc       = 3'b000;
    case (state_reg)
      S_FETCH: begin
        mem.MemReq = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        IrWrite    = mem.MemReady;
        PcWrite    = mem.MemReady;
        if (mem.MemReady) state_next = S_DECODE;
        else if (timeout_hit) begin
          state_next = S_HALT;
          cause_next = 2'b10;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = 3'b010;
        case (op)
          7'b1100011: state_next = S_BRANCH;
          7'b0110111: state_next = S_LUI;
          7'b0010111: state_next = S_AUIPC;
          7'b0000011, 7'b0100011: state_next = (func3 == 3'b010) ? S_MEMADR : S_HALT;
          7'b0110011: state_next = S_EXEC_R;
          7'b0010011: state_next = S_EXEC_I;
          7'b1101111: state_next = S_JAL;
          7'b1100111: state_next = (func3 == 3'b000) ? S_JALR : S_HALT;
          default:    state_next = S_HALT;
        endcase
        if (state_next == S_HALT) cause_next = 2'b01;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        state_next = S_FETCH;
        case (func3)
          3'b000:  PcWrite = Zero;
          3'b001:  PcWrite = !Zero;
          3'b100:  PcWrite = sign;
          3'b101:  PcWrite = !sign;
          3'b110:  PcWrite = Ltu;
          3'b111:  PcWrite = !Ltu;
          default: begin
            state_next = S_HALT;
            cause_next = 2'b01;
          end
        endcase
      end
      S_LUI: begin
        ImmSrc     = 3'b011;
        ResultSrc  = 2'b11;
        RegWrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_AUIPC: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b01;
        ImmSrc     = 3'b011;
        state_next = S_ALUWB;
      end
      S_MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ImmSrc     = op[5] ? 3'b001 : 3'b000;
        state_next = op[5] ? S_MEMWR : S_MEMRD;
      end
      S_MEMWR: begin
        mem.MemReq   = 1'b1;
        mem.MemWrite = 1'b1;
        mem.AdrSrc   = 1'b1;
        if (mem.MemReady) state_next = S_FETCH;
        else if (timeout_hit) begin
          state_next = S_HALT;
          cause_next = 2'b10;
        end
      end
      S_MEMRD: begin
        mem.MemReq = 1'b1;
        mem.AdrSrc = 1'b1;
        if (mem.MemReady) state_next = S_MEMWB;
        else if (timeout_hit) begin
          state_next = S_HALT;
          cause_next = 2'b10;
        end
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_EXEC_R: begin
        ALUSrcA    = 2'b10;
        state_next = S_ALUWB;
        case ({func7, func3})
          10'b0000000_000: ALUControl = ALU_ADD;
          10'b0100000_000: ALUControl = ALU_SUB;
          10'b0000000_111: ALUControl = ALU_AND;
          10'b0000000_110: ALUControl = ALU_OR;
          10'b0000000_100: ALUControl = ALU_XOR;
          10'b0000000_010: ALUControl = ALU_SLT;
          10'b0000000_011: ALUControl = ALU_SLTU;
          default: begin
            state_next = S_HALT;
            cause_next = 2'b01;
          end
        endcase
      end
      S_EXEC_I: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        state_next = S_ALUWB;
        case (func3)
          3'b000:  ALUControl = ALU_ADD;
          3'b111:  ALUControl = ALU_AND;
          3'b110:  ALUControl = ALU_OR;
          3'b100:  ALUControl = ALU_XOR;
          3'b010:  ALUControl = ALU_SLT;
          3'b011:  ALUControl = ALU_SLTU;
          default: begin
            state_next = S_HALT;
            cause_next = 2'b01;
          end
        endcase
      end
      S_ALUWB, S_JUMPWB: begin
        RegWrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b01;
        ImmSrc     = 3'b100;
        state_next = S_JUMP;
      end
      S_JALR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        state_next = S_JUMP;
      end
      // ALUOut holds the target; meanwhile OldPC+4 is formed as the link value.
      S_JUMP: begin
        PcWrite    = 1'b1;
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        state_next = S_JUMPWB;
      end
      default: state_next = S_HALT;
    endcase
  end

  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (state_next != state_reg) wait_cnt_next = '0;
    else if (in_req_state && !mem.MemReady && (wait_cnt_reg != WAIT_LIMIT))
      wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_FETCH;
      cause_reg    <= 2'b00;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cause_reg    <= cause_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  assign Halted = (state_reg == S_HALT);
  assign Cause  = cause_reg;

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_reg, instret_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_reg   <= '0;
      instret_cnt_reg <= '0;
    end else begin
      if (state_reg != S_HALT) cycle_cnt_reg <= cycle_cnt_reg + CNT_W'(1);
      if ((state_next == S_FETCH) && (state_reg != S_FETCH))
        instret_cnt_reg <= instret_cnt_reg + CNT_W'(1);
    end
  end

  assign CycleCnt   = cycle_cnt_reg;
  assign InstretCnt = instret_cnt_reg;
`endif

endmodule

// File: tb/tb_mc_controller_v2.sv
// Directed-vector bench for mc_controller_v2: per-cycle control vectors against hand-built constants.
// Instance a uses MEM_TIMEOUT=16, b uses 4, c uses 0 (no timeout).
module tb_mc_controller_v2;
  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op, func7;
  logic [2:0] func3;
  logic       Zero, sign, Ltu;

  always #5 clk = ~clk;

  mc_controller_v2_if if_a();
  mc_controller_v2_if if_b();
  mc_controller_v2_if if_c();

  logic a_irw, a_pcw, a_rw, a_halt, b_irw, b_pcw, b_rw, b_halt, c_irw, c_pcw, c_rw, c_halt;
  logic [1:0] a_asa, a_asb, a_rs, a_cause, b_asa, b_asb, b_rs, b_cause, c_asa, c_asb, c_rs, c_cause;
  logic [3:0] a_alu, b_alu, c_alu;
  logic [2:0] a_imm, b_imm, c_imm;
`ifdef MC_PERF_CNT_EN
  logic [31:0] a_cyc, a_ret, b_cyc, b_ret, c_cyc, c_ret;
`endif

  mc_controller_v2 #(.MEM_TIMEOUT(16), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .mem(if_a), .op(op), .func3(func3), .func7(func7),
    .Zero(Zero), .sign(sign), .Ltu(Ltu), .IrWrite(a_irw), .PcWrite(a_pcw), .RegWrite(a_rw),
    .ALUSrcA(a_asa), .ALUSrcB(a_asb), .ResultSrc(a_rs), .ALUControl(a_alu), .ImmSrc(a_imm),
    .Halted(a_halt), .Cause(a_cause)
`ifdef MC_PERF_CNT_EN
    , .CycleCnt(a_cyc), .InstretCnt(a_ret)
`endif
  );

  mc_controller_v2 #(.MEM_TIMEOUT(4), .CNT_W(32)) dut_b (
    .clk(clk), .rst(rst), .mem(if_b), .op(op), .func3(func3), .func7(func7),
    .Zero(Zero), .sign(sign), .Ltu(Ltu), .IrWrite(b_irw), .PcWrite(b_pcw), .RegWrite(b_rw),
    .ALUSrcA(b_asa), .ALUSrcB(b_asb), .ResultSrc(b_rs), .ALUControl(b_alu), .ImmSrc(b_imm),
    .Halted(b_halt), .Cause(b_cause)
`ifdef MC_PERF_CNT_EN
    , .CycleCnt(b_cyc), .InstretCnt(b_ret)
`endif
  );

  mc_controller_v2 #(.MEM_TIMEOUT(0), .CNT_W(32)) dut_c (
    .clk(clk), .rst(rst), .mem(if_c), .op(op), .func3(func3), .func7(func7),
    .Zero(Zero), .sign(sign), .Ltu(Ltu), .IrWrite(c_irw), .PcWrite(c_pcw), .RegWrite(c_rw),
    .ALUSrcA(c_asa), .ALUSrcB(c_asb), .ResultSrc(c_rs), .ALUControl(c_alu), .ImmSrc(c_imm),
    .Halted(c_halt), .Cause(c_cause)
`ifdef MC_PERF_CNT_EN
    , .CycleCnt(c_cyc), .InstretCnt(c_ret)
`endif
  );

  // {MemReq,MemWrite,AdrSrc,IrWrite,PcWrite,RegWrite, ALUSrcA,ALUSrcB,ResultSrc, ALUControl, ImmSrc, Halted,Cause}
  logic [21:0] ctl_a;
  assign ctl_a = {if_a.MemReq, if_a.MemWrite, if_a.AdrSrc, a_irw, a_pcw, a_rw,
                  a_asa, a_asb, a_rs, a_alu, a_imm, a_halt, a_cause};

  localparam logic [21:0] C_FETCH_W = {6'b100000, 2'b00, 2'b10, 2'b10, 4'b0000, 3'b000, 3'b000};
  localparam logic [21:0] C_FETCH   = {6'b100110, 2'b00, 2'b10, 2'b10, 4'b0000, 3'b000, 3'b000};
  localparam logic [21:0] C_DECODE  = {6'b000000, 2'b01, 2'b01, 2'b00, 4'b0000, 3'b010, 3'b000};
  localparam logic [21:0] C_EXI_ADD = {6'b000000, 2'b10, 2'b01, 2'b00, 4'b0000, 3'b000, 3'b000};
  localparam logic [21:0] C_EXR_SUB = {6'b000000, 2'b10, 2'b00, 2'b00, 4'b0001, 3'b000, 3'b000};
  localparam logic [21:0] C_ALUWB   = {6'b000001, 2'b00, 2'b00, 2'b00, 4'b0000, 3'b000, 3'b000};
  localparam logic [21:0] C_MA_L    = {6'b000000, 2'b10, 2'b01, 2'b00, 4'b0000, 3'b000, 3'b000};
  localparam logic [21:0] C_MA_S    = {6'b000000, 2'b10, 2'b01, 2'b00, 4'b0000, 3'b001, 3'b000};
  localparam logic [21:0] C_MRD     = {6'b101000, 2'b00, 2'b00, 2'b00, 4'b0000, 3'b000, 3'b000};
  localparam logic [21:0] C_MWR     = {6'b111000, 2'b00, 2'b00, 2'b00, 4'b0000, 3'b000, 3'b000};
  localparam logic [21:0] C_MEMWB   = {6'b000001, 2'b00, 2'b00, 2'b01, 4'b0000, 3'b000, 3'b000};
  localparam logic [21:0] C_BR_T    = {6'b000010, 2'b10, 2'b00, 2'b00, 4'b0001, 3'b000, 3'b000};
  localparam logic [21:0] C_BR_N    = {6'b000000, 2'b10, 2'b00, 2'b00, 4'b0001, 3'b000, 3'b000};
  localparam logic [21:0] C_JAL     = {6'b000000, 2'b01, 2'b01, 2'b00, 4'b0000, 3'b100, 3'b000};
  localparam logic [21:0] C_JUMP    = {6'b000010, 2'b01, 2'b10, 2'b00, 4'b0000, 3'b000, 3'b000};
  localparam logic [21:0] C_HALT1   = {6'b000000, 2'b00, 2'b00, 2'b00, 4'b0000, 3'b000, 3'b101};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Check instance a's control vector for the current cycle, then move to the next cycle.
  task automatic cyc(input string tag, input logic [21:0] exp);
    #1;
    check(tag, 32'(ctl_a), 32'(exp));
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    op = 7'd0; func3 = 3'd0; func7 = 7'd0; Zero = 1'b0; sign = 1'b0; Ltu = 1'b0;
    if_a.MemReady = 1'b0; if_b.MemReady = 1'b0; if_c.MemReady = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    // Fetch stalls: b times out after its 4 wait cycles, c never does.
    for (int i = 0; i < 4; i++) begin
      #1;
      check("tmo4_waiting", 32'({if_b.MemReq, b_halt}), 32'(2'b10));
      cyc(i == 0 ? "reset_outputs" : "fetch_wait", C_FETCH_W);
    end
    cyc("fetch_wait", C_FETCH_W);
    cyc("fetch_wait", C_FETCH_W);
    #1;
    check("tmo4_halt", 32'({if_b.MemReq, b_halt, b_cause}), 32'(4'b0110));
    check("tmo0_waiting", 32'({if_c.MemReq, c_halt}), 32'(2'b10));

    // addi
    if_a.MemReady = 1'b1; op = 7'b0010011; func3 = 3'b000;
    cyc("addi_fetch", C_FETCH);
    cyc("addi_decode", C_DECODE);
    cyc("addi_exec", C_EXI_ADD);
    cyc("addi_wb", C_ALUWB);
`ifdef MC_PERF_CNT_EN
    check("addi_instret", a_ret, 32'd1);
    check("addi_cyclecnt", a_cyc, 32'd10);
`endif

    // lw with three wait states in MEMREAD
    op = 7'b0000011; func3 = 3'b010;
    cyc("lw_fetch", C_FETCH);
    cyc("lw_decode", C_DECODE);
    cyc("lw_memadr", C_MA_L);
    if_a.MemReady = 1'b0;
    for (int i = 0; i < 3; i++) cyc("lw_memread_wait", C_MRD);
    if_a.MemReady = 1'b1;
    cyc("lw_memread_done", C_MRD);
    cyc("lw_memwb", C_MEMWB);

    // bltu taken, bgeu not taken, both with Ltu=1
    op = 7'b1100011; func3 = 3'b110; Ltu = 1'b1;
    cyc("bltu_fetch", C_FETCH);
    cyc("bltu_decode", C_DECODE);
    cyc("bltu_branch", C_BR_T);
    func3 = 3'b111;
    cyc("bgeu_fetch", C_FETCH);
    cyc("bgeu_decode", C_DECODE);
    cyc("bgeu_branch", C_BR_N);

    // sub
    op = 7'b0110011; func3 = 3'b000; func7 = 7'b0100000;
    cyc("sub_fetch", C_FETCH);
    cyc("sub_decode", C_DECODE);
    cyc("sub_exec", C_EXR_SUB);
    cyc("sub_wb", C_ALUWB);

    // jal
    op = 7'b1101111; func7 = 7'd0;
    cyc("jal_fetch", C_FETCH);
    cyc("jal_decode", C_DECODE);
    cyc("jal_target", C_JAL);
    cyc("jal_jump", C_JUMP);
    cyc("jal_wb", C_ALUWB);

    // sw interrupted by reset while waiting in MEMWRITE
    op = 7'b0100011; func3 = 3'b010;
    cyc("sw_fetch", C_FETCH);
    cyc("sw_decode", C_DECODE);
    cyc("sw_memadr", C_MA_S);
    if_a.MemReady = 1'b0;
    cyc("sw_memwrite", C_MWR);
    rst = 1'b1;
    cyc("sw_memwrite_rst", C_MWR);
    rst = 1'b0;
`ifdef MC_PERF_CNT_EN
    #1;
    check("rst_instret", a_ret, 32'd0);
    check("rst_cyclecnt", a_cyc, 32'd0);
`endif
    cyc("sw_rst_fetch", C_FETCH_W);

    // Illegal opcode (fence) halts with cause 01
    if_a.MemReady = 1'b1; op = 7'b0001111; func3 = 3'b000;
    cyc("ill_fetch", C_FETCH);
    cyc("ill_decode", C_DECODE);
    cyc("ill_halt", C_HALT1);
`ifdef MC_PERF_CNT_EN
    check("halt_cyclecnt", a_cyc, 32'd3);
`endif
    cyc("halt_hold", C_HALT1);
    if_a.MemReady = 1'b0;
    cyc("halt_hold", C_HALT1);
`ifdef MC_PERF_CNT_EN
    check("halt_cyclecnt_frozen", a_cyc, 32'd3);
`endif
    rst = 1'b1;
    cyc("halt_rst_edge", C_HALT1);
    rst = 1'b0;

    // After reset: b gets MemReady exactly when its wait counter sits at the limit
    for (int i = 0; i < 4; i++) begin
      #1;
      check("tmo4_rewait", 32'({b_halt, b_cause}), 32'(3'b000));
      cyc(i == 0 ? "halt_rst_fetch" : "fetch_wait", C_FETCH_W);
    end
    if_b.MemReady = 1'b1;
    #1;
    check("tmo4_ready_wins", 32'({b_irw, b_halt}), 32'(2'b10));
    cyc("fetch_wait", C_FETCH_W);
    if_b.MemReady = 1'b0;
    #1;
    check("tmo4_after_ready", 32'({if_b.MemReq, b_halt}), 32'(2'b00));
    check("tmo0_still_waiting", 32'({if_c.MemReq, c_halt, c_cause}), 32'(4'b1000));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
